// File: rtl/mem_stage_ctrl.sv
// MEM stage control: issues LW/SW to multi-cycle data memory,
// stalls upstream until completion, and loads the MEM/WB register.
module mem_stage_ctrl #(
    parameter int DATA_W  = 16,
    parameter int REG_W   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_memr,
    input  logic              in_memw,
    input  logic              in_regwrite,
    input  logic [REG_W-1:0]  in_dst,
    input  logic [DATA_W-1:0] in_alu,
    input  logic [DATA_W-1:0] in_sdata,
    input  logic              in_hlt,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_done,
    output logic              stall_m,
    output logic              wb_regwrite,
    output logic [REG_W-1:0]  wb_dst,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_hlt,
    output logic [31:0]       cyc_cnt,
    output logic [31:0]       stall_cnt,
    output logic              err
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        HALTED
    } state_t;

    state_t state;
    state_t stateNext;

    logic [CW-1:0]     waitCnt;
    logic              isMem;
    logic              isLoad;
    logic              wbWe;
    logic [DATA_W-1:0] wbData;
    logic              hltRet;

    // a simultaneous memr+memw is a store, so a load needs memw low
    assign isMem  = in_valid & (in_memr | in_memw);
    assign isLoad = in_memr & ~in_memw;

    // next state, memory request, stall and the MEM/WB next value
    always_comb begin
        stateNext = state;
        mem_en    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        stall_m   = 1'b0;
        wbWe      = 1'b0;
        wbData    = in_alu;
        hltRet    = 1'b0;
        unique case (state)
            IDLE: begin
                if (isMem) begin
                    mem_en    = 1'b1;
                    mem_wr    = in_memw;
                    mem_addr  = in_alu;
                    mem_wdata = in_sdata;
                    stall_m   = 1'b1;
                    stateNext = WAIT;
                end else begin
                    wbWe = in_valid & in_regwrite;
                    if (in_valid && in_hlt) begin
                        hltRet    = 1'b1;
                        stateNext = HALTED;
                    end
                end
            end
            WAIT: begin
                if (mem_done) begin
                    wbWe      = in_regwrite & isLoad;
                    wbData    = isLoad ? mem_rdata : in_alu;
                    stateNext = IDLE;
                end else begin
                    stall_m = 1'b1;
                end
            end
            HALTED: begin
                stall_m = 1'b1;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
        if (rst) begin
            mem_en    = 1'b0;
            mem_wr    = 1'b0;
            mem_addr  = '0;
            mem_wdata = '0;
            stall_m   = 1'b0;
        end
    end

    // state register; reset abandons any outstanding request
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // WAIT watchdog: saturating counter, err is sticky until reset
    always_ff @(posedge clk) begin
        if (rst) begin
            waitCnt <= '0;
            err     <= 1'b0;
        end else if (state == IDLE) begin
            waitCnt <= '0;
        end else if (state == WAIT && !mem_done) begin
            if (waitCnt != CW'(TIMEOUT)) begin
                waitCnt <= waitCnt + 1'b1;
            end
            if (waitCnt == CW'(TIMEOUT - 1)) begin
                err <= 1'b1;
            end
        end
    end

    // MEM/WB register; frozen except regwrite once halted
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_regwrite <= 1'b0;
            wb_dst      <= '0;
            wb_data     <= '0;
            wb_hlt      <= 1'b0;
        end else if (state == HALTED) begin
            wb_regwrite <= 1'b0;
        end else begin
            wb_regwrite <= wbWe;
            wb_dst      <= in_dst;
            wb_data     <= wbData;
            if (hltRet) begin
                wb_hlt <= 1'b1;
            end
        end
    end

    // cycle and stall counters, frozen while halted
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_cnt   <= '0;
            stall_cnt <= '0;
        end else if (state != HALTED) begin
            cyc_cnt <= cyc_cnt + 32'd1;
            if (stall_m) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: directed scenarios plus randomized
// instruction stream checked against a transaction-level model.
module tb_mem_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_memr;
    logic        in_memw;
    logic        in_regwrite;
    logic [3:0]  in_dst;
    logic [15:0] in_alu;
    logic [15:0] in_sdata;
    logic        in_hlt;
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_done;
    logic        stall_m;
    logic        wb_regwrite;
    logic [3:0]  wb_dst;
    logic [15:0] wb_data;
    logic        wb_hlt;
    logic [31:0] cyc_cnt;
    logic [31:0] stall_cnt;
    logic        err;

    int checks = 0;
    int errors = 0;
    int expCyc = 0;
    int expStall = 0;
    bit halted = 0;

    always #5 clk = ~clk;

    mem_stage_ctrl #(
        .DATA_W (16),
        .REG_W  (4),
        .TIMEOUT(64)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_memr    (in_memr),
        .in_memw    (in_memw),
        .in_regwrite(in_regwrite),
        .in_dst     (in_dst),
        .in_alu     (in_alu),
        .in_sdata   (in_sdata),
        .in_hlt     (in_hlt),
        .mem_en     (mem_en),
        .mem_wr     (mem_wr),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_done   (mem_done),
        .stall_m    (stall_m),
        .wb_regwrite(wb_regwrite),
        .wb_dst     (wb_dst),
        .wb_data    (wb_data),
        .wb_hlt     (wb_hlt),
        .cyc_cnt    (cyc_cnt),
        .stall_cnt  (stall_cnt),
        .err        (err)
    );

    // one clock; model: cycles since reset, frozen once halted
    task automatic tick();
        bit r;
        r = rst;
        @(posedge clk);
        #1;
        if (r) begin
            expCyc   = 0;
            expStall = 0;
            halted   = 0;
        end else if (!halted) begin
            expCyc++;
        end
    endtask

    task automatic idle_inputs();
        in_valid    = 0;
        in_memr     = 0;
        in_memw     = 0;
        in_regwrite = 0;
        in_hlt      = 0;
        mem_done    = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        idle_inputs();
        in_dst    = 0;
        in_alu    = 0;
        in_sdata  = 0;
        mem_rdata = 0;
        tick();
        tick();
        checks++;
        if ({mem_en, stall_m, wb_regwrite, wb_hlt, err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags got %b want 00000",
                     {mem_en, stall_m, wb_regwrite, wb_hlt, err});
        end
        checks++;
        if (cyc_cnt !== 0 || stall_cnt !== 0 || wb_data !== 0) begin
            errors++;
            $display("FAIL reset_cnt got cyc=%0d stall=%0d data=%h want 0",
                     cyc_cnt, stall_cnt, wb_data);
        end
        rst = 0;
    endtask

    // one memory instruction with done after lat cycles
    task automatic run_mem(input bit r, input bit w, input bit rw,
                           input logic [3:0] d, input logic [15:0] a,
                           input logic [15:0] sd, input logic [15:0] rd,
                           input int lat);
        bit ld;
        logic [15:0] expData;
        ld = r & ~w;
        expData = ld ? rd : a;
        in_valid    = 1;
        in_memr     = r;
        in_memw     = w;
        in_regwrite = rw;
        in_dst      = d;
        in_alu      = a;
        in_sdata    = sd;
        in_hlt      = 0;
        mem_done    = 0;
        #1;
        checks++;
        if (mem_en !== 1 || mem_wr !== w || stall_m !== 1) begin
            errors++;
            $display("FAIL req_ctl got en=%b wr=%b st=%b want 1 %b 1",
                     mem_en, mem_wr, stall_m, w);
        end
        checks++;
        if (mem_addr !== a || mem_wdata !== sd) begin
            errors++;
            $display("FAIL req_bus got %h/%h want %h/%h",
                     mem_addr, mem_wdata, a, sd);
        end
        tick();
        for (int k = 1; k < lat; k++) begin
            checks++;
            if (mem_en !== 0 || stall_m !== 1 || wb_regwrite !== 0) begin
                errors++;
                $display("FAIL wait_%0d got en=%b st=%b we=%b want 0 1 0",
                         k, mem_en, stall_m, wb_regwrite);
            end
            tick();
        end
        mem_done  = 1;
        mem_rdata = rd;
        #1;
        checks++;
        if (stall_m !== 0 || mem_en !== 0) begin
            errors++;
            $display("FAIL done_stall got st=%b en=%b want 0 0",
                     stall_m, mem_en);
        end
        tick();
        mem_done  = 0;
        in_valid  = 0;
        mem_rdata = 16'($urandom);
        expStall += lat;
        checks++;
        if (wb_regwrite !== (rw & ld) || wb_data !== expData) begin
            errors++;
            $display("FAIL mem_wb got we=%b data=%h want %b %h",
                     wb_regwrite, wb_data, rw & ld, expData);
        end
        checks++;
        if (wb_dst !== d) begin
            errors++;
            $display("FAIL mem_dst got %0d want %0d", wb_dst, d);
        end
        checks++;
        if (cyc_cnt !== expCyc || stall_cnt !== expStall) begin
            errors++;
            $display("FAIL mem_cnt got %0d/%0d want %0d/%0d",
                     cyc_cnt, stall_cnt, expCyc, expStall);
        end
    endtask

    // non-memory instruction, optionally with a stray mem_done
    task automatic run_alu(input bit v, input bit rw, input logic [3:0] d,
                           input logic [15:0] a, input bit stray);
        in_valid    = v;
        in_memr     = v ? 1'b0 : 1'($urandom);
        in_memw     = 0;
        in_regwrite = rw;
        in_dst      = d;
        in_alu      = a;
        in_hlt      = 0;
        mem_done    = stray;
        #1;
        checks++;
        if (stall_m !== 0 || mem_en !== 0) begin
            errors++;
            $display("FAIL alu_stall got st=%b en=%b want 0 0",
                     stall_m, mem_en);
        end
        tick();
        in_valid = 0;
        in_memr  = 0;
        mem_done = 0;
        checks++;
        if (wb_regwrite !== (v & rw)) begin
            errors++;
            $display("FAIL alu_we got %b want %b", wb_regwrite, v & rw);
        end
        if (v) begin
            checks++;
            if (wb_dst !== d || wb_data !== a) begin
                errors++;
                $display("FAIL alu_wb got %0d/%h want %0d/%h",
                         wb_dst, wb_data, d, a);
            end
        end
        checks++;
        if (cyc_cnt !== expCyc || stall_cnt !== expStall) begin
            errors++;
            $display("FAIL alu_cnt got %0d/%0d want %0d/%0d",
                     cyc_cnt, stall_cnt, expCyc, expStall);
        end
    endtask

    task automatic test_lw();
        run_mem(1, 0, 1, 4'd7, 16'h0040, 16'h0000, 16'hBEEF, 4);
        checks++;
        if (stall_cnt !== 4) begin
            errors++;
            $display("FAIL lw_stall_cnt got %0d want 4", stall_cnt);
        end
    endtask

    task automatic test_alu();
        run_alu(1, 1, 4'd3, 16'h1234, 0);
    endtask

    task automatic test_sw();
        run_mem(0, 1, 1, 4'd2, 16'h0010, 16'h00AA, 16'h5555, 2);
        run_mem(1, 1, 1, 4'd9, 16'h0022, 16'h1111, 16'h9999, 1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            int op;
            op = $urandom_range(0, 4);
            case (op)
                0: run_alu(1, 1'($urandom), 4'($urandom),
                           16'($urandom), 1'($urandom));
                1: run_mem(1, 0, 1'($urandom), 4'($urandom), 16'($urandom),
                           16'($urandom), 16'($urandom),
                           $urandom_range(1, 6));
                2: run_mem(0, 1, 1'($urandom), 4'($urandom), 16'($urandom),
                           16'($urandom), 16'($urandom),
                           $urandom_range(1, 6));
                3: run_mem(1, 1, 1'($urandom), 4'($urandom), 16'($urandom),
                           16'($urandom), 16'($urandom),
                           $urandom_range(1, 6));
                default: run_alu(0, 1, 4'($urandom),
                                 16'($urandom), 1'($urandom));
            endcase
        end
    endtask

    task automatic test_reset_in_wait();
        in_valid    = 1;
        in_memr     = 1;
        in_memw     = 0;
        in_regwrite = 1;
        in_dst      = 4'd6;
        in_alu      = 16'h0080;
        tick();
        tick();
        rst = 1;
        idle_inputs();
        tick();
        rst = 0;
        checks++;
        if (cyc_cnt !== 0 || stall_cnt !== 0 || stall_m !== 0) begin
            errors++;
            $display("FAIL rstwait_state got cyc=%0d stall=%0d st=%b want 0",
                     cyc_cnt, stall_cnt, stall_m);
        end
        mem_done  = 1;
        mem_rdata = 16'hDEAD;
        #1;
        checks++;
        if (stall_m !== 0 || mem_en !== 0) begin
            errors++;
            $display("FAIL rstwait_done got st=%b en=%b want 0 0",
                     stall_m, mem_en);
        end
        tick();
        mem_done = 0;
        checks++;
        if (wb_regwrite !== 0 || cyc_cnt !== expCyc || stall_cnt !== 0) begin
            errors++;
            $display("FAIL rstwait_wb got we=%b cyc=%0d stall=%0d want 0 %0d 0",
                     wb_regwrite, cyc_cnt, stall_cnt, expCyc);
        end
    endtask

    task automatic test_timeout();
        in_valid    = 1;
        in_memr     = 1;
        in_memw     = 0;
        in_regwrite = 1;
        in_alu      = 16'h0100;
        tick();
        for (int k = 1; k < 64; k++) tick();
        checks++;
        if (err !== 0 || stall_m !== 1) begin
            errors++;
            $display("FAIL timeout_early got err=%b st=%b want 0 1",
                     err, stall_m);
        end
        tick();
        checks++;
        if (err !== 1 || stall_m !== 1) begin
            errors++;
            $display("FAIL timeout_err got err=%b st=%b want 1 1",
                     err, stall_m);
        end
        tick();
        checks++;
        if (err !== 1) begin
            errors++;
            $display("FAIL timeout_sticky got %b want 1", err);
        end
        rst = 1;
        idle_inputs();
        tick();
        rst = 0;
        checks++;
        if (err !== 0) begin
            errors++;
            $display("FAIL timeout_clear got %b want 0", err);
        end
    endtask

    task automatic test_halt();
        run_alu(1, 1, 4'd1, 16'h0011, 0);
        in_valid    = 1;
        in_hlt      = 1;
        in_regwrite = 1;
        in_dst      = 4'd5;
        in_alu      = 16'h0077;
        #1;
        checks++;
        if (stall_m !== 0) begin
            errors++;
            $display("FAIL hlt_stall got %b want 0", stall_m);
        end
        tick();
        halted = 1;
        checks++;
        if (wb_hlt !== 1 || wb_regwrite !== 1 || wb_data !== 16'h0077) begin
            errors++;
            $display("FAIL hlt_wb got hlt=%b we=%b data=%h want 1 1 0077",
                     wb_hlt, wb_regwrite, wb_data);
        end
        in_hlt  = 0;
        in_memr = 1;
        in_alu  = 16'h0040;
        #1;
        checks++;
        if (mem_en !== 0 || stall_m !== 1) begin
            errors++;
            $display("FAIL halted_req got en=%b st=%b want 0 1",
                     mem_en, stall_m);
        end
        for (int k = 0; k < 6; k++) begin
            mem_done = 1'(k & 1);
            tick();
        end
        checks++;
        if (wb_hlt !== 1 || wb_regwrite !== 0 || mem_en !== 0) begin
            errors++;
            $display("FAIL halted_wb got hlt=%b we=%b en=%b want 1 0 0",
                     wb_hlt, wb_regwrite, mem_en);
        end
        checks++;
        if (cyc_cnt !== expCyc || stall_cnt !== expStall) begin
            errors++;
            $display("FAIL halted_cnt got %0d/%0d want %0d/%0d",
                     cyc_cnt, stall_cnt, expCyc, expStall);
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_alu();
        test_sw();
        test_random();
        test_reset_in_wait();
        test_timeout();
        test_halt();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
